// File: rtl/risc_fu_pkg.sv
// Shared function-unit definitions: FS select codes and
// the multiply sequencer state type.
package risc_fu_pkg;

  localparam logic [4:0] FS_PASSA = 5'b00000;
  localparam logic [4:0] FS_PASSB = 5'b00001;
  localparam logic [4:0] FS_ADD   = 5'b00010;
  localparam logic [4:0] FS_ADDC  = 5'b00011;
  localparam logic [4:0] FS_INC   = 5'b00100;
  localparam logic [4:0] FS_SUB   = 5'b00101;
  localparam logic [4:0] FS_SUBB  = 5'b00110;
  localparam logic [4:0] FS_DEC   = 5'b00111;
  localparam logic [4:0] FS_AND   = 5'b01000;
  localparam logic [4:0] FS_OR    = 5'b01001;
  localparam logic [4:0] FS_XOR   = 5'b01010;
  localparam logic [4:0] FS_NOT   = 5'b01011;
  localparam logic [4:0] FS_SLL   = 5'b01100;
  localparam logic [4:0] FS_SRL   = 5'b01101;
  localparam logic [4:0] FS_SRA   = 5'b01110;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } mul_state_t;

endpackage

// File: rtl/fu_mul_sequencer_if.sv
// Borrowed function-unit port: req/gnt handshake,
// operand/select steering and combinational result.
interface fu_mul_sequencer_if #(
  parameter int WIDTH = 32
);

  logic             fu_req;
  logic             fu_gnt;
  logic [WIDTH-1:0] fu_a;
  logic [WIDTH-1:0] fu_b;
  logic [4:0]       fu_sh;
  logic [4:0]       fu_fs;
  logic [WIDTH-1:0] fu_f;
  logic             fu_c;

  modport master (
    output fu_req,
    output fu_a,
    output fu_b,
    output fu_sh,
    output fu_fs,
    input  fu_gnt,
    input  fu_f,
    input  fu_c
  );

  modport slave (
    input  fu_req,
    input  fu_a,
    input  fu_b,
    input  fu_sh,
    input  fu_fs,
    output fu_gnt,
    output fu_f,
    output fu_c
  );

endinterface

// File: rtl/fu_mul_sequencer.sv
// Unsigned shift-and-add multiplier that borrows the
// shared function unit for one ADD per iteration.
module fu_mul_sequencer
  import risc_fu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic               CLK,
  input  logic               RESET,
  input  logic               start,
  input  logic               abort,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product,
  fu_mul_sequencer_if.master fu
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  mul_state_t state;

  logic [WIDTH-1:0]   m_q;
  logic [WIDTH-1:0]   q_q;
  logic [WIDTH-1:0]   p_q;
  logic [CW-1:0]      cnt;
  logic               req_q;
  logic               run;
  logic [2*WIDTH-1:0] nxt;

  assign run = (state == RUN);

  // carry of the add becomes the top bit of shifted P
  assign nxt = {fu.fu_c, fu.fu_f, q_q[WIDTH-1:1]};

  assign fu.fu_req = req_q;
  assign fu.fu_a   = run ? p_q : '0;
  assign fu.fu_b   = (run && q_q[0]) ? m_q : '0;
  assign fu.fu_sh  = '0;
  assign fu.fu_fs  = FS_ADD;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state   <= IDLE;
      m_q     <= '0;
      q_q     <= '0;
      p_q     <= '0;
      cnt     <= '0;
      product <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      req_q   <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            m_q   <= a;
            q_q   <= b;
            p_q   <= '0;
            cnt   <= '0;
            state <= RUN;
            busy  <= 1'b1;
            req_q <= 1'b1;
          end
        end
        RUN: begin
          if (abort) begin
            state <= IDLE;
            busy  <= 1'b0;
            req_q <= 1'b0;
          end else if (fu.fu_gnt) begin
            {p_q, q_q} <= nxt;
            cnt        <= cnt + 1'b1;
            if (cnt == LAST) begin
              product <= nxt;
              state   <= DONE;
              done    <= 1'b1;
              req_q   <= 1'b0;
            end
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          req_q <= 1'b0;
        end
      endcase
    end
  end

endmodule
